// File: rtl/flick_pkg.sv
// Shared types and defaults for the flick input conditioner.
// State encoding is fixed at 2 bits.
package flick_pkg;

    typedef enum logic [1:0] {
        IDLE_LOW     = 2'd0,
        CONFIRM_HIGH = 2'd1,
        STABLE_HIGH  = 2'd2,
        CONFIRM_LOW  = 2'd3
    } state_t;

    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_HOLD_CYCLES     = 16;

endpackage

// File: rtl/flick_debouncer_sync.sv
// Multi-flop synchroniser for one asynchronous bit.
// Synchronous active-high reset clears the chain to 0.
module bit_synchronizer #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], d};
        end
    end

    assign q = r_sync[STAGES-1];

endmodule

// File: rtl/flick_debouncer.sv
// Flick input conditioner: sync, debounce, rise/fall pulses.
// Long-press pulse only when FLICK_HOLD_EN is defined.
module flick_debouncer
    import flick_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic flick_raw,
    output logic flick_clean,
    output logic flick_rise,
    output logic flick_fall,
    output logic flick_hold
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES);

    logic    w_s;
    state_t  r_state;
    logic [CW-1:0] r_cnt;
    logic    r_clean;
    logic    r_rise;
    logic    r_fall;

    bit_synchronizer #(.STAGES(SYNC_STAGES)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (flick_raw),
        .q   (w_s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE_LOW;
            r_cnt   <= '0;
            r_clean <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            unique case (r_state)
                IDLE_LOW: begin
                    if (w_s) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            r_state <= STABLE_HIGH;
                            r_clean <= 1'b1;
                            r_rise  <= 1'b1;
                            r_cnt   <= '0;
                        end else begin
                            r_state <= CONFIRM_HIGH;
                            r_cnt   <= CW'(1);
                        end
                    end
                end
                CONFIRM_HIGH: begin
                    if (!w_s) begin
                        r_state <= IDLE_LOW;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= STABLE_HIGH;
                        r_clean <= 1'b1;
                        r_rise  <= 1'b1;
                        r_cnt   <= '0;
                    end else if (r_cnt != CNT_MAX) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                STABLE_HIGH: begin
                    if (!w_s) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            r_state <= IDLE_LOW;
                            r_clean <= 1'b0;
                            r_fall  <= 1'b1;
                            r_cnt   <= '0;
                        end else begin
                            r_state <= CONFIRM_LOW;
                            r_cnt   <= CW'(1);
                        end
                    end
                end
                CONFIRM_LOW: begin
                    if (w_s) begin
                        r_state <= STABLE_HIGH;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= IDLE_LOW;
                        r_clean <= 1'b0;
                        r_fall  <= 1'b1;
                        r_cnt   <= '0;
                    end else if (r_cnt != CNT_MAX) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    assign flick_clean = r_clean;
    assign flick_rise  = r_rise;
    assign flick_fall  = r_fall;

`ifdef FLICK_HOLD_EN
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYCLES);
    localparam logic [HW-1:0] HOLD_PREV = HW'(HOLD_CYCLES - 1);

    logic          w_enter_high;
    logic          w_stay_high;
    logic [HW-1:0] r_hold_cnt;
    logic          r_hold_pend;
    logic          r_hold;

    assign w_stay_high  = w_s && (r_state == STABLE_HIGH);
    assign w_enter_high = w_s && (
        (r_state == CONFIRM_HIGH && r_cnt == CNT_LAST) ||
        (r_state == IDLE_LOW && DEBOUNCE_CYCLES == 1) ||
        (r_state == CONFIRM_LOW));

    // Pulse lands the cycle after the count saturates, so clean has been high HOLD_CYCLES cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_cnt  <= '0;
            r_hold_pend <= 1'b0;
            r_hold      <= 1'b0;
        end else begin
            r_hold      <= r_hold_pend && w_stay_high;
            r_hold_pend <= 1'b0;
            if (w_enter_high) begin
                r_hold_cnt  <= HW'(1);
                r_hold_pend <= (HOLD_CYCLES == 1);
            end else if (w_stay_high) begin
                if (r_hold_cnt != HOLD_MAX) begin
                    r_hold_cnt  <= r_hold_cnt + 1'b1;
                    r_hold_pend <= (r_hold_cnt == HOLD_PREV);
                end
            end else begin
                r_hold_cnt <= '0;
            end
        end
    end

    assign flick_hold = r_hold;
`else
    assign flick_hold = 1'b0;
`endif

endmodule

// File: tb/tb_flick_debouncer.sv
// Scoreboard bench for flick_debouncer (default parameters).
// Expected pulses are queued by stimulus and popped by a negedge monitor.
module tb_flick_debouncer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flick_raw = 1'b1;
    logic flick_clean;
    logic flick_rise;
    logic flick_fall;
    logic flick_hold;

    typedef struct {
        logic [2:0] kind;
        int         cyc;
    } ev_t;

    localparam logic [2:0] K_RISE = 3'b001;
    localparam logic [2:0] K_FALL = 3'b010;
    localparam logic [2:0] K_HOLD = 3'b100;

    ev_t q[$];
    int  cyc  = 0;
    int  nchk = 0;
    int  nerr = 0;

    flick_debouncer dut (
        .clk         (clk),
        .rst         (rst),
        .flick_raw   (flick_raw),
        .flick_clean (flick_clean),
        .flick_rise  (flick_rise),
        .flick_fall  (flick_fall),
        .flick_hold  (flick_hold)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic expect_ev(input logic [2:0] k, input int c);
        ev_t e;
        e.kind = k;
        e.cyc  = c;
        q.push_back(e);
    endtask

    task automatic wait_to(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [3:0] got, input logic [3:0] want);
        nchk++;
        if (got !== want) begin
            nerr++;
            $display("FAIL %s cyc=%0d got=%b want=%b", name, cyc, got, want);
        end
    endtask

    // Monitor: every pulse must match the head of the queue in kind and cycle.
    always @(negedge clk) begin
        logic [2:0] act;
        ev_t e;
        act = {flick_hold, flick_fall, flick_rise};
        if (act != 3'b000) begin
            nchk++;
            if (q.size() == 0) begin
                nerr++;
                $display("FAIL unexpected_pulse cyc=%0d got=%b want=none", cyc, act);
            end else begin
                e = q.pop_front();
                if (e.kind !== act || e.cyc != cyc) begin
                    nerr++;
                    $display("FAIL pulse cyc=%0d got=%b want=%b@%0d", cyc, act, e.kind, e.cyc);
                end
                nchk++;
                if (flick_clean !== (e.kind != K_FALL)) begin
                    nerr++;
                    $display("FAIL clean_at_pulse cyc=%0d got=%b want=%b", cyc, flick_clean, e.kind != K_FALL);
                end
            end
        end
    end

    initial begin
        // Reset held two edges with raw high
        @(negedge clk);
        chk("reset_outs_1", {flick_clean, flick_rise, flick_fall, flick_hold}, 4'b0000);
        @(negedge clk);
        chk("reset_outs_2", {flick_clean, flick_rise, flick_fall, flick_hold}, 4'b0000);
        rst = 1'b0;
        expect_ev(K_RISE, 8);
        wait_to(7);
        chk("reset_clean_before", {3'b000, flick_clean}, 4'b0000);
        wait_to(12);
        chk("reset_clean_after", {3'b000, flick_clean}, 4'b0001);

        // Release with bounce: last 1->0 at 16
        flick_raw = 1'b0; wait_to(13);
        flick_raw = 1'b1; wait_to(14);
        flick_raw = 1'b0; wait_to(15);
        flick_raw = 1'b1; wait_to(16);
        flick_raw = 1'b0;
        expect_ev(K_FALL, 22);
        wait_to(21);
        chk("bounce_clean_hold", {3'b000, flick_clean}, 4'b0001);

        // Clean press, 100ns
        wait_to(30);
        flick_raw = 1'b1;
        expect_ev(K_RISE, 36);
        wait_to(35);
        chk("press_clean_5", {3'b000, flick_clean}, 4'b0000);
        wait_to(36);
        chk("press_clean_6", {3'b000, flick_clean}, 4'b0001);
        wait_to(40);
        flick_raw = 1'b0;
        expect_ev(K_FALL, 46);

        // Three-cycle glitch: rejected
        wait_to(50);
        flick_raw = 1'b1;
        wait_to(53);
        flick_raw = 1'b0;
        wait_to(59);
        chk("glitch_clean", {3'b000, flick_clean}, 4'b0000);

        // Six-cycle high with one low inside, then stays high
        flick_raw = 1'b1; wait_to(62);
        flick_raw = 1'b0; wait_to(63);
        flick_raw = 1'b1;
        expect_ev(K_RISE, 69);
        wait_to(68);
        chk("dip_clean_before", {3'b000, flick_clean}, 4'b0000);
        wait_to(75);
        flick_raw = 1'b0;
        expect_ev(K_FALL, 81);

        // Reset while in CONFIRM_HIGH with cnt=2
        wait_to(90);
        flick_raw = 1'b1;
        wait_to(94);
        rst = 1'b1;
        wait_to(95);
        chk("midreset_outs", {flick_clean, flick_rise, flick_fall, flick_hold}, 4'b0000);
        rst = 1'b0;
        expect_ev(K_RISE, 101);
        wait_to(100);
        chk("midreset_clean_before", {3'b000, flick_clean}, 4'b0000);
        wait_to(105);
        flick_raw = 1'b0;
        expect_ev(K_FALL, 111);

        // Long press, 40 cycles
        wait_to(120);
        flick_raw = 1'b1;
        expect_ev(K_RISE, 126);
`ifdef FLICK_HOLD_EN
        expect_ev(K_HOLD, 142);
`endif
        wait_to(160);
        chk("long_clean", {3'b000, flick_clean}, 4'b0001);
        flick_raw = 1'b0;
        expect_ev(K_FALL, 166);

        wait_to(180);
        chk("final_clean", {3'b000, flick_clean}, 4'b0000);
        nchk++;
        if (q.size() != 0) begin
            nerr++;
            $display("FAIL missing_pulses got=%0d_left want=0 next=%b@%0d", q.size(), q[0].kind, q[0].cyc);
        end
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
